// File: rtl/pipe_reg_elastic.sv
// Elastic multi-stage pipeline register with bubble collapse and sync flush; latency STAGES cycles, 1 word/cycle.
// Backpressure: a stalled output holds q; empty stages still advance, and in_ready drops only when full and stalled.
module pipe_reg_elastic #(
  parameter int            N         = 8,
  parameter int            STAGES    = 3,
  parameter logic [N-1:0]  RST_VAL   = '0,
  parameter logic [N-1:0]  FLUSH_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N-1:0]                    d,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N-1:0]                    q,
  output logic [$clog2(STAGES+1)-1:0]     occupancy
);
  localparam int OW = $clog2(STAGES + 1);

  logic [STAGES-1:0] r_v;
  logic [N-1:0]      r_dat [STAGES];

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_up_v;
  logic [N-1:0]      w_up_d [STAGES];
  logic              w_carry;
  logic [OW-1:0]     w_occ;

  // A stage may move when the one ahead moves or when it holds nothing.
  always_comb begin
    w_adv             = '0;
    w_carry           = out_ready | ~r_v[STAGES-1];
    w_adv[STAGES-1]   = w_carry;
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_carry  = w_carry | ~r_v[i];
      w_adv[i] = w_carry;
    end
  end

  always_comb begin
    w_up_v    = '0;
    w_up_v[0] = in_valid;
    w_up_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      w_up_v[i] = r_v[i-1];
      w_up_d[i] = r_dat[i-1];
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ = w_occ + OW'(r_v[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_dat[i] <= RST_VAL;
      end
    end else if (flush) begin
      r_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_dat[i] <= FLUSH_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_adv[i]) begin
          r_v[i] <= w_up_v[i];
          // Data is only replaced by a real word, so an emptied stage keeps its last value.
          if (w_up_v[i]) begin
            r_dat[i] <= w_up_d[i];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0] & ~flush & rst_n;
  assign out_valid = r_v[STAGES-1];
  assign q         = r_dat[STAGES-1];
  assign occupancy = w_occ;

endmodule
